conwaylife_loader: RTL and testbench



---
 rtl/conwaylife_loader.sv | 143 ++++++++++++++
 tb/tb_conwaylife_loader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conwaylife_loader.sv
// -----------------------------------------------------------------------------
// conwaylife_loader
//
// Row-serial board loader for the 16x16 Conway's Life engine. Sixteen 16-bit
// rows arrive over a valid/ready stream and are assembled into a 256-bit board.
// When the last row is accepted the complete board is issued on `data` together
// with a one-cycle `load` pulse. The issued board is held stable while the next
// frame is assembled in a separate buffer.
//
// Optional feature macro: CONWAYLIFE_LOADER_IDX_CHECK_EN
//   When defined, each accepted beat's `row_idx` is compared with the internal
//   row counter. A mismatch drops the beat, pulses `err` and discards the
//   partial frame. When undefined, `row_idx` is ignored and `err` is tied to 0.
//
// Ports:
//   clk          in   rising-edge clock shared with the engine
//   areset_n     in   asynchronous active-low reset
//   row_valid    in   upstream row beat valid
//   row_ready    out  loader accepts a row this cycle (registered)
//   row_data     in   row cells, bit c = column c
//   row_idx      in   row number of this beat (index check build only)
//   frame_abort  in   discard the partially assembled frame
//   load         out  one-cycle pulse to the engine's load input
//   data         out  issued board, cell (r,c) at bit 16*r+c
//   frame_cnt    out  number of boards issued, wraps at 256
//   err          out  one-cycle row-index error pulse
// -----------------------------------------------------------------------------
module conwaylife_loader #(
    parameter int W = 16,
    parameter int H = 16
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             row_valid,
    output logic             row_ready,
    input  logic [W-1:0]     row_data,
    input  logic [3:0]       row_idx,
    input  logic             frame_abort,
    output logic             load,
    output logic [W*H-1:0]   data,
    output logic [7:0]       frame_cnt,
    output logic             err
);

    typedef enum logic {
        FILL  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    localparam logic [3:0] LAST_ROW = 4'(H - 1);

    state_t           state;
    logic [3:0]       row_cnt;
    logic [W*H-1:0]   buffer;
    logic [W*H-1:0]   assembled;

    // Buffer with the incoming row merged in at the current row slot. On the
    // last row this is the complete board, so it can be issued on the same
    // edge without waiting a cycle for the buffer to update.
    // NOTE: every variable assigned in always_comb gets a full default first,
    // otherwise a latch is inferred for the paths that skip it.
    always_comb begin
        assembled = buffer;
        assembled[row_cnt*W +: W] = row_data;
    end

`ifndef CONWAYLIFE_LOADER_IDX_CHECK_EN
    // Index check not built: row_idx has no load and err is constant.
    logic unused_row_idx;
    assign unused_row_idx = ^row_idx;
    assign err = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state     <= FILL;
            row_ready <= 1'b0;
            load      <= 1'b0;
            data      <= '0;
            frame_cnt <= '0;
            row_cnt   <= '0;
            // NOTE: the wide assembly buffer is reset explicitly; it is plain
            // flops, not a RAM, so a reset costs nothing structurally and keeps
            // its contents deterministic.
            buffer    <= '0;
`ifdef CONWAYLIFE_LOADER_IDX_CHECK_EN
            err       <= 1'b0;
`endif
        end else begin
            load <= 1'b0;
`ifdef CONWAYLIFE_LOADER_IDX_CHECK_EN
            err  <= 1'b0;
`endif
            case (state)
                FILL: begin
                    row_ready <= 1'b1;
                    if (frame_abort) begin
                        // Abort wins over a beat in the same cycle; the stale
                        // buffer rows are overwritten by the next frame.
                        row_cnt <= '0;
                    end else if (row_valid && row_ready) begin
`ifdef CONWAYLIFE_LOADER_IDX_CHECK_EN
                        if (row_idx != row_cnt) begin
                            err     <= 1'b1;
                            row_cnt <= '0;
                        end else
`endif
                        begin
                            buffer <= assembled;
                            if (row_cnt == LAST_ROW) begin
                                // Last row: issue straight from the merged
                                // board so load is high in the next cycle.
                                row_cnt   <= '0;
                                state     <= ISSUE;
                                row_ready <= 1'b0;
                                load      <= 1'b1;
                                data      <= assembled;
                                frame_cnt <= frame_cnt + 8'd1;
                            end else begin
                                row_cnt <= row_cnt + 4'd1;
                            end
                        end
                    end
                end

                ISSUE: begin
                    // Single bubble cycle while load is high; frame_abort has
                    // no effect here.
                    state     <= FILL;
                    row_ready <= 1'b1;
                end

                default: begin
                    state     <= FILL;
                    row_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conwaylife_loader.sv
// -----------------------------------------------------------------------------
// tb_conwaylife_loader
//
// Directed self-checking bench for conwaylife_loader. Rows are pushed through a
// bounded valid/ready handshake; load pulses, ready bubbles and err pulses are
// counted by a monitor on the falling edge. Expected boards are hand-derived
// constants or simple bit patterns built by the bench.
// -----------------------------------------------------------------------------
module tb_conwaylife_loader;

    logic         clk         = 1'b0;
    logic         areset_n    = 1'b0;
    logic         row_valid   = 1'b0;
    logic [15:0]  row_data    = '0;
    logic [3:0]   row_idx     = '0;
    logic         frame_abort = 1'b0;
    logic         row_ready;
    logic         load;
    logic [255:0] data;
    logic [7:0]   frame_cnt;
    logic         err;

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int load_cnt  = 0;
    int load_cyc  = 0;
    int ready_low = 0;
    int err_cnt   = 0;
    int acc_cyc   = 0;
    bit stuck     = 1'b0;

    conwaylife_loader #(.W(16), .H(16)) dut (
        .clk         (clk),
        .areset_n    (areset_n),
        .row_valid   (row_valid),
        .row_ready   (row_ready),
        .row_data    (row_data),
        .row_idx     (row_idx),
        .frame_abort (frame_abort),
        .load        (load),
        .data        (data),
        .frame_cnt   (frame_cnt),
        .err         (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Falling-edge monitor: outputs are stable mid-cycle.
    always @(negedge clk) begin
        if (areset_n) begin
            if (load) begin
                load_cnt++;
                load_cyc = cyc;
            end
            if (!row_ready) ready_low++;
            if (err) err_cnt++;
        end
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted (bounded wait).
    task automatic push_row(input logic [15:0] d, input logic [3:0] idx, input logic abort);
        int n;
        if (stuck) return;
        row_valid   = 1'b1;
        row_data    = d;
        row_idx     = idx;
        frame_abort = abort;
        @(negedge clk);
        n = 0;
        while (row_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (row_ready !== 1'b1) begin
            check("row_ready_timeout", row_ready, 1'b1);
            stuck       = 1'b1;
            row_valid   = 1'b0;
            frame_abort = 1'b0;
            return;
        end
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        row_valid   = 1'b0;
        frame_abort = 1'b0;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        areset_n = 1'b0;
        @(negedge clk);
        areset_n = 1'b1;
        step();
    endtask

    function automatic logic [15:0] glider_row(input int k);
        case (k)
            0:       return 16'h0002;
            1:       return 16'h0004;
            2:       return 16'h0007;
            default: return 16'h0000;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got time limit expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [255:0] diag;
        logic [255:0] glider;
        int           first_acc;

        glider = 256'h0000_0007_0004_0002;
        diag   = '0;
        for (int k = 0; k < 16; k++) diag[17*k] = 1'b1;

        // Reset state.
        #23;
        check("rst_row_ready", row_ready, 1'b0);
        check("rst_load", load, 1'b0);
        check("rst_data", data, '0);
        check("rst_frame_cnt", frame_cnt, 8'd0);
        check("rst_err", err, 1'b0);
        areset_n = 1'b1;
        step();
        check("ready_after_release", row_ready, 1'b1);

        // Diagonal frame, back-to-back beats.
        load_cnt  = 0;
        first_acc = 0;
        for (int k = 0; k < 16; k++) begin
            push_row(16'h0001 << k, 4'(k), 1'b0);
            if (k == 0) first_acc = acc_cyc;
        end
        check("diag_load", load, 1'b1);
        check("diag_data", data, diag);
        check("diag_frame_cnt", frame_cnt, 8'd1);
        step();
        check("diag_load_drop", load, 1'b0);
        check("diag_ready_back", row_ready, 1'b1);
        check("diag_load_count", 32'(load_cnt), 32'd1);
        check("diag_load_cycle", 32'(load_cyc - first_acc), 32'd16);

        // Two consecutive frames: glider then zeros.
        reset_pulse();
        ready_low = 0;
        load_cnt  = 0;
        for (int k = 0; k < 16; k++) push_row(glider_row(k), 4'(k), 1'b0);
        check("glider_load", load, 1'b1);
        check("glider_data", data, glider);
        for (int k = 0; k < 16; k++) begin
            push_row(16'h0000, 4'(k), 1'b0);
            if (k == 14) check("glider_hold", data, glider);
        end
        check("zero_load", load, 1'b1);
        check("zero_data", data, '0);
        check("two_frame_cnt", frame_cnt, 8'd2);
        step();
        check("two_ready_bubbles", 32'(ready_low), 32'd2);
        check("two_load_count", 32'(load_cnt), 32'd2);

        // Abort with row 7 valid, then a fresh all-ones frame.
        load_cnt = 0;
        for (int k = 0; k < 7; k++) push_row(16'h1234, 4'(k), 1'b0);
        push_row(16'h1234, 4'd7, 1'b1);
        step();
        step();
        step();
        check("abort_no_load", 32'(load_cnt), 32'd0);
        check("abort_frame_cnt", frame_cnt, 8'd2);
        check("abort_data_held", data, '0);
        for (int k = 0; k < 16; k++) push_row(16'hFFFF, 4'(k), 1'b0);
        check("ones_load", load, 1'b1);
        check("ones_data", data, {256{1'b1}});
        check("ones_frame_cnt", frame_cnt, 8'd3);
        step();
        check("ones_load_count", 32'(load_cnt), 32'd1);

        // Asynchronous reset after row 10.
        for (int k = 0; k < 11; k++) push_row(16'h5555, 4'(k), 1'b0);
        #3;
        areset_n = 1'b0;
        #1;
        check("async_row_ready", row_ready, 1'b0);
        check("async_load", load, 1'b0);
        check("async_data", data, '0);
        check("async_frame_cnt", frame_cnt, 8'd0);
        check("async_err", err, 1'b0);
        @(negedge clk);
        areset_n = 1'b1;
        step();
        check("post_rst_ready", row_ready, 1'b1);
        load_cnt = 0;
        for (int k = 0; k < 16; k++) push_row(16'hA5A5, 4'(k), 1'b0);
        check("post_rst_load", load, 1'b1);
        check("post_rst_data", data, {16{16'hA5A5}});
        check("post_rst_frame_cnt", frame_cnt, 8'd1);
        step();
        check("post_rst_load_count", 32'(load_cnt), 32'd1);

        // frame_cnt wrap: 255 -> 0 -> 1.
        reset_pulse();
        for (int f = 1; f <= 257; f++) begin
            for (int k = 0; k < 16; k++) push_row(16'h0000, 4'(k), 1'b0);
            if (f == 255) check("wrap_255", frame_cnt, 8'd255);
            if (f == 256) check("wrap_0", frame_cnt, 8'd0);
            if (f == 257) check("wrap_1", frame_cnt, 8'd1);
        end

        // Row 3 sent with row_idx = 5.
        reset_pulse();
        err_cnt  = 0;
        load_cnt = 0;
        for (int k = 0; k < 3; k++) push_row(16'h0008, 4'(k), 1'b0);
        push_row(16'h0008, 4'd5, 1'b0);
`ifdef CONWAYLIFE_LOADER_IDX_CHECK_EN
        check("idx_err_pulse", err, 1'b1);
        check("idx_no_load", load, 1'b0);
        step();
        check("idx_err_drop", err, 1'b0);
        for (int k = 0; k < 16; k++) push_row(16'h000F, 4'(k), 1'b0);
        check("idx_next_load", load, 1'b1);
        check("idx_next_data", data, {16{16'h000F}});
        step();
        check("idx_err_count", 32'(err_cnt), 32'd1);
        check("idx_load_count", 32'(load_cnt), 32'd1);
`else
        check("idx_err_off", err, 1'b0);
        for (int k = 4; k < 16; k++) push_row(16'h0008, 4'(k), 1'b0);
        check("idx_off_load", load, 1'b1);
        check("idx_off_data", data, {16{16'h0008}});
        step();
        check("idx_off_err_count", 32'(err_cnt), 32'd0);
        check("idx_off_load_count", 32'(load_cnt), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
